apb_fsm_controller: RTL and testbench
=====================================

// Module: apb_fsm_controller
// PURPOSE
//  AHB-to-APB bridge sequencer. Sits directly upstream of the APB output interface and drives its Pwrite/Penable/Pselx/Paddr/Pwdata.
//  Accepts one qualified AHB transfer at a time from the AHB slave front-end and runs the APB SETUP then ENABLE phases.
//  Inserts AHB wait states through Hreadyout and returns read data on Hrdata.
// PARAMETERS
//  ADDR_W  32  address width (Haddr, Paddr)
//  DATA_W  32  data width (Hwdata, Pwdata, Prdata, Hrdata)
//  SEL_W   3   one-hot peripheral select width (tempselx, Pselx)
// PORTS
//  Hclk       in   1       clock; everything is on the rising edge
//  Hreset     in   1       synchronous, active-high reset
//  valid      in   1       AHB address phase holds a NONSEQ/SEQ transfer to the bridge
//  Haddr      in   ADDR_W  AHB address, sampled in the address phase
//  Hwrite     in   1       1 = write, 0 = read; sampled in the address phase
//  tempselx   in   SEL_W   decoded one-hot slave select, sampled in the address phase
//  Hwdata     in   DATA_W  AHB write data, valid in the data phase
//  Prdata     in   DATA_W  APB read data from the selected peripheral
//  Pwrite     out  1       APB write strobe (registered)
//  Penable    out  1       APB enable (registered)
//  Pselx      out  SEL_W   APB select (registered)
//  Paddr      out  ADDR_W  APB address (registered)
//  Pwdata     out  DATA_W  APB write data (registered)
//  Hreadyout  out  1       AHB ready: 0 inserts a wait state
//  Hrdata     out  DATA_W  AHB read data
// BEHAVIOUR
//  Accept point
//  - accept = valid && Hreadyout && (tempselx != 0).
//  - On accept, latch Haddr, Hwrite and tempselx into addr_r, wr_r and sel_r.
//  - valid is ignored while Hreadyout = 0.
//  - A transfer with tempselx = 0 is not accepted and is dropped.
//  States: IDLE, WWAIT, READ, RENABLE, WRITE, WENABLE. All outputs are Moore outputs decoded from the registered state.
//  Per-state transitions and outputs
//  - IDLE: Hreadyout=1; Pselx=0; Penable=0.
//    - accept && !Hwrite -> READ.
//    - accept && Hwrite -> WWAIT.
//    - otherwise stay.
//  - WWAIT: Hreadyout=0; Pselx=0. Latch Hwdata into wdata_r; the master holds Hwdata because Hreadyout=0. -> WRITE.
//  - READ: Pselx=sel_r; Paddr=addr_r; Pwrite=0; Penable=0; Hreadyout=0. -> RENABLE.
//  - WRITE: Pselx=sel_r; Paddr=addr_r; Pwrite=1; Pwdata=wdata_r; Penable=0; Hreadyout=0. -> WENABLE.
//  - RENABLE: same as READ, except Penable=1 and Hreadyout=1. Hrdata=Prdata (combinational pass-through).
//  - WENABLE: same as WRITE, except Penable=1 and Hreadyout=1.
//  - Exit from RENABLE and WENABLE:
//    - accept && !Hwrite -> READ.
//    - accept && Hwrite -> WWAIT.
//    - otherwise -> IDLE.
//    - This gives back-to-back transfers with no IDLE cycle.
//  Hold and default rules
//  - Paddr, Pwrite and Pwdata keep their last value in IDLE and WWAIT; only Pselx and Penable return to 0.
//  - Hrdata = 0 in every state other than RENABLE.
//  Latency (address phase in cycle N)
//  - Read: SETUP at N+1, ENABLE at N+2. Hreadyout is 0 at N+1 and 1 at N+2, so there is 1 wait state.
//  - Write: WWAIT at N+1, SETUP at N+2, ENABLE at N+3. Hreadyout is 0 at N+1 and N+2, 1 at N+3, so there are 2 wait states.
//  - APB peripherals are zero-wait; PREADY is not supported.
//  Reset
//  - Hreset=1 at any edge forces state to IDLE.
//  - Outputs after reset: Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1, Hrdata=0.
//  - wdata_r, addr_r, sel_r and wr_r are cleared to 0.
//  - Reset during SETUP or ENABLE aborts the transfer; Pselx is 0 on the next cycle.
//  - Hreset has priority over accept in the same cycle.
//  Invariant: Penable=1 only in the cycle directly after a SETUP cycle with the same Pselx/Paddr.
// TESTING
//  T1 reset: hold Hreset 2 cycles mid-write -> next cycle Pselx=0, Penable=0, Hreadyout=1, state IDLE.
//  T2 read: valid, Hwrite=0, Haddr=0x8000_0010, tempselx=3'b001, Prdata=0x19 ->
//     N+1: Pselx=001, Penable=0, Hreadyout=0.
//     N+2: Penable=1, Hreadyout=1, Hrdata=0x19.
//     N+3: IDLE.
//  T3 write: Haddr=0x8400_0004, tempselx=010, Hwdata=0xDEAD_BEEF at N+1 ->
//     N+2: Pwrite=1, Pwdata=0xDEADBEEF, Penable=0.
//     N+3: Penable=1, Hreadyout=1.
//  T4 back-to-back: read accepted during RENABLE with a new read at 0x8000_0020 ->
//     next cycle is READ with Paddr=0x8000_0020 and no IDLE cycle.
//     Repeat with write then read.
//  T5 drop/ignore: valid=1 with tempselx=0 -> stays IDLE, Pselx=0.
//     valid toggled while Hreadyout=0 -> no extra transfer.
//  T6 mixed: 20 random read/write transfers; scoreboard checks the APB sequence, the Penable invariant and Hrdata.

Source files
------------

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge sequencer: one transfer at a time through SETUP/ENABLE, AHB wait states via Hreadyout.
// Reads take 1 wait state, writes 2 (extra cycle to capture data-phase Hwdata); back-to-back from ENABLE.
module apb_fsm_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [SEL_W-1:0]  tempselx,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Pwrite,
    output logic              Penable,
    output logic [SEL_W-1:0]  Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata
);

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        READ,
        RENABLE,
        WRITE,
        WENABLE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pwrite_q, pwrite_d;
    logic                penable_q, penable_d;
    logic [SEL_W-1:0]    pselx_q, pselx_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                accept;

    assign Hreadyout = (state_q == IDLE) || (state_q == RENABLE) || (state_q == WENABLE);
    assign accept    = valid && Hreadyout && (tempselx != '0);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        paddr_d   = paddr_q;
        pselx_d   = '0;
        penable_d = 1'b0;

        if (accept) begin
            addr_d = Haddr;
            wr_d   = Hwrite;
            sel_d  = tempselx;
        end

        case (state_q)
            IDLE, RENABLE, WENABLE: begin
                if (accept) state_d = Hwrite ? WWAIT : READ;
                else        state_d = IDLE;
            end
            WWAIT: begin
                wdata_d = Hwdata;
                state_d = WRITE;
            end
            READ:    state_d = RENABLE;
            WRITE:   state_d = WENABLE;
            default: state_d = IDLE;
        endcase

        // APB outputs are registered: decode them from the state being entered.
        // The _d copies cover a SETUP entered on the same edge as the accept or data capture.
        case (state_d)
            READ, WRITE: begin
                pselx_d  = sel_d;
                paddr_d  = addr_d;
                pwrite_d = wr_d;
                if (state_d == WRITE) pwdata_d = wdata_d;
            end
            RENABLE, WENABLE: begin
                pselx_d   = sel_q;
                penable_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            sel_q     <= '0;
            wdata_q   <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            pselx_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            pselx_q   <= pselx_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign Pwrite  = pwrite_q;
    assign Penable = penable_q;
    assign Pselx   = pselx_q;
    assign Paddr   = paddr_q;
    assign Pwdata  = pwdata_q;
    assign Hrdata  = (state_q == RENABLE) ? Prdata : '0;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Scoreboarded bench for apb_fsm_controller: directed latency checks plus a monitor checking every APB access.
module tb_apb_fsm_controller;

    logic        Hclk = 1'b0;
    logic        Hreset, valid, Hwrite;
    logic [31:0] Haddr, Hwdata, Prdata;
    logic [2:0]  tempselx;
    logic        Pwrite, Penable, Hreadyout;
    logic [2:0]  Pselx;
    logic [31:0] Paddr, Pwdata, Hrdata;

    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Haddr(Haddr), .Hwrite(Hwrite),
        .tempselx(tempselx), .Hwdata(Hwdata), .Prdata(Prdata), .Pwrite(Pwrite),
        .Penable(Penable), .Pselx(Pselx), .Paddr(Paddr), .Pwdata(Pwdata),
        .Hreadyout(Hreadyout), .Hrdata(Hrdata)
    );

    always #5 Hclk = ~Hclk;

    typedef struct packed {
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Zero-wait peripheral model: read data depends only on the address presented.
    function automatic logic [31:0] periph(input logic [31:0] a);
        return (a == 32'h8000_0010) ? 32'h19 : (a ^ 32'hA5A5_0F0F);
    endfunction

    assign Prdata = periph(Paddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every ENABLE cycle retires one scoreboard entry.
    logic        prev_setup = 1'b0;
    logic [2:0]  prev_sel   = '0;
    logic [31:0] prev_addr  = '0;

    always @(negedge Hclk) begin
        exp_t e;
        if (Hreset) begin
            prev_setup = 1'b0;
        end else begin
            if (Penable) begin
                chk("enable_after_setup", 32'(prev_setup), 1);
                chk("enable_sel_stable", 32'(Pselx), 32'(prev_sel));
                chk("enable_addr_stable", Paddr, prev_addr);
                chk("xfer_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("mon_pwrite", 32'(Pwrite), 32'(e.wr));
                    chk("mon_pselx", 32'(Pselx), 32'(e.sel));
                    chk("mon_paddr", Paddr, e.addr);
                    chk("mon_hready", 32'(Hreadyout), 1);
                    if (e.wr) chk("mon_pwdata", Pwdata, e.wdata);
                    else      chk("mon_hrdata", Hrdata, e.rdata);
                end
            end else begin
                chk("mon_hrdata_zero", Hrdata, 0);
            end
            if (Pselx != 3'b000 && !Penable) chk("setup_wait_state", 32'(Hreadyout), 0);
            prev_setup = (Pselx != 3'b000) && !Penable;
            prev_sel   = Pselx;
            prev_addr  = Paddr;
        end
    end

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    // Presents one address phase once Hreadyout allows; returns one cycle later (#1 after the edge).
    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] wd);
        int   guard = 0;
        exp_t e;
        while (!Hreadyout && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("issue_timeout", 32'(Hreadyout), 1);
        valid    = 1'b1;
        Hwrite   = wr;
        Haddr    = a;
        tempselx = s;
        @(posedge Hclk);
        if (s != 3'b000) begin
            e.wr = wr; e.sel = s; e.addr = a; e.wdata = wd; e.rdata = periph(a);
            sb_q.push_back(e);
        end
        #1;
        valid    = 1'b0;
        tempselx = 3'b000;
        if (wr) Hwdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wr;
        logic [2:0]  s;
        logic [31:0] a;
        Hreset = 1'b1; valid = 1'b0; Hwrite = 1'b0; Haddr = '0; tempselx = '0; Hwdata = '0;
        repeat (3) step();
        Hreset = 1'b0;
        chk("rst_pselx", 32'(Pselx), 0);
        chk("rst_penable", 32'(Penable), 0);
        chk("rst_pwrite", 32'(Pwrite), 0);
        chk("rst_paddr", Paddr, 0);
        chk("rst_pwdata", Pwdata, 0);
        chk("rst_hready", 32'(Hreadyout), 1);
        chk("rst_hrdata", Hrdata, 0);

        // Read latency
        issue(1'b0, 32'h8000_0010, 3'b001, 32'h0);
        chk("t2_n1_pselx", 32'(Pselx), 1);
        chk("t2_n1_penable", 32'(Penable), 0);
        chk("t2_n1_hready", 32'(Hreadyout), 0);
        chk("t2_n1_paddr", Paddr, 32'h8000_0010);
        step();
        chk("t2_n2_penable", 32'(Penable), 1);
        chk("t2_n2_hready", 32'(Hreadyout), 1);
        chk("t2_n2_hrdata", Hrdata, 32'h19);
        step();
        chk("t2_n3_pselx", 32'(Pselx), 0);
        chk("t2_n3_penable", 32'(Penable), 0);
        chk("t2_n3_paddr_hold", Paddr, 32'h8000_0010);

        // Write latency
        issue(1'b1, 32'h8400_0004, 3'b010, 32'hDEAD_BEEF);
        chk("t3_n1_hready", 32'(Hreadyout), 0);
        chk("t3_n1_pselx", 32'(Pselx), 0);
        step();
        chk("t3_n2_pwrite", 32'(Pwrite), 1);
        chk("t3_n2_pwdata", Pwdata, 32'hDEAD_BEEF);
        chk("t3_n2_penable", 32'(Penable), 0);
        chk("t3_n2_pselx", 32'(Pselx), 2);
        chk("t3_n2_hready", 32'(Hreadyout), 0);
        step();
        chk("t3_n3_penable", 32'(Penable), 1);
        chk("t3_n3_hready", 32'(Hreadyout), 1);
        step();

        // Back-to-back: read after read, then read after write
        issue(1'b0, 32'h8000_0010, 3'b001, 32'h0);
        step();
        issue(1'b0, 32'h8000_0020, 3'b100, 32'h0);
        chk("t4_rr_paddr", Paddr, 32'h8000_0020);
        chk("t4_rr_pselx", 32'(Pselx), 4);
        chk("t4_rr_penable", 32'(Penable), 0);
        step();
        issue(1'b1, 32'h8000_1000, 3'b010, 32'h1234_5678);
        step();
        step();
        issue(1'b0, 32'h8000_0030, 3'b001, 32'h0);
        chk("t4_wr_paddr", Paddr, 32'h8000_0030);
        chk("t4_wr_pselx", 32'(Pselx), 1);
        chk("t4_wr_pwrite", 32'(Pwrite), 0);
        step();
        step();

        // Dropped select and valid while stalled
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0040; tempselx = 3'b000;
        step();
        chk("t5_drop_pselx", 32'(Pselx), 0);
        chk("t5_drop_hready", 32'(Hreadyout), 1);
        valid = 1'b0;
        issue(1'b0, 32'h8000_0050, 3'b001, 32'h0);
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_9999; tempselx = 3'b001;
        step();
        valid = 1'b0; tempselx = 3'b000;
        step();
        chk("t5_no_extra_pselx", 32'(Pselx), 0);
        chk("t5_no_extra_hready", 32'(Hreadyout), 1);

        // Reset held two cycles in the middle of a write
        issue(1'b1, 32'h8000_2000, 3'b100, 32'hCAFE_F00D);
        step();
        Hreset = 1'b1;
        step();
        step();
        Hreset = 1'b0;
        void'(sb_q.pop_back());
        chk("t1_pselx", 32'(Pselx), 0);
        chk("t1_penable", 32'(Penable), 0);
        chk("t1_hready", 32'(Hreadyout), 1);
        chk("t1_paddr", Paddr, 0);
        chk("t1_pwdata", Pwdata, 0);
        step();
        chk("t1_idle_pselx", 32'(Pselx), 0);

        // Mixed traffic
        for (int i = 0; i < 20; i++) begin
            wr = 1'($urandom_range(0, 1));
            s  = 3'(1 << $urandom_range(0, 2));
            a  = {16'h8000, 16'($urandom) & 16'hFFFC};
            issue(wr, a, s, $urandom);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (5) step();
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
